// File: rtl/ibex_bus_pkg.sv
// Shared types and helpers for the core bus responder.
// Response bundle, word size and address range check.
package ibex_bus_pkg;

    localparam int unsigned BusWordBytes = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } bus_resp_t;

    // Addresses below base wrap to a huge offset and fail the check.
    function automatic logic bus_addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] words
    );
        logic [31:0] off;
        off = addr - base;
        return (off >> $clog2(BusWordBytes)) < words;
    endfunction

endpackage

// File: rtl/ibex_bus_resp_pipe.sv
// Fixed-latency response pipeline for the bus responder.
// Every stage shifts every cycle; reset drops in-flight responses.
module ibex_bus_resp_pipe
    import ibex_bus_pkg::*;
#(
    parameter int unsigned RespLatency = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      valid_i,
    input  bus_resp_t resp_i,
    output logic      valid_o,
    output bus_resp_t resp_o
);

    logic [RespLatency-1:0] valid_q;
    bus_resp_t              resp_q [RespLatency];

    // Shift valid and payload one stage per cycle; idle stages hold zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            resp_q[0]  <= valid_i ? resp_i : '0;
            for (int i = 1; i < RespLatency; i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[RespLatency-1];
    assign resp_o  = valid_o ? resp_q[RespLatency-1] : '0;

endmodule

// File: rtl/ibex_bus_responder.sv
// Memory-side responder for the core req/gnt/rvalid bus.
// Word RAM, request decode and outstanding-transaction limit.
module ibex_bus_responder
    import ibex_bus_pkg::*;
#(
    parameter logic [31:0] AddrBase       = 32'h0010_0000,
    parameter int unsigned MemWords       = 16384,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;

    logic [31:0]     mem_q [MemWords];
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [IdxW-1:0] idx;
    logic            acc;
    logic            dec_err;
    logic            wr_en;
    logic            rvalid;
    bus_resp_t       resp_d;
    bus_resp_t       resp_out;

    assign gnt_o   = req_i & ~stall_i & (cnt_q < CntW'(MaxOutstanding));
    assign acc     = req_i & gnt_o;
    assign idx     = IdxW'((addr_i - AddrBase) >> 2);
    assign dec_err = ~bus_addr_in_range(addr_i, AddrBase, MemWords)
                   | (addr_i[1:0] != 2'b00);
    // A write accepted while reset is high is dropped.
    assign wr_en   = acc & we_i & ~dec_err & ~rst_i;

    // Build the response: old RAM word for good reads, zero otherwise.
    always_comb begin
        resp_d       = '0;
        resp_d.err   = dec_err;
        if (!we_i && !dec_err) begin
            resp_d.rdata = mem_q[idx];
        end
    end

    // Byte-enabled RAM write; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Outstanding count: up on acceptance, down on response.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({acc, rvalid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    ibex_bus_resp_pipe #(
        .RespLatency(RespLatency)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(acc),
        .resp_i (resp_d),
        .valid_o(rvalid),
        .resp_o (resp_out)
    );

    assign rvalid_o = rvalid;
    assign rdata_o  = resp_out.rdata;
    assign err_o    = resp_out.err;

endmodule
